sysbus_mem_responder: RTL and testbench

- Memory-side responder on the Sysbus request/response protocol.
- Accepts line requests from a core-side initiator such as the fetch unit.
- Reads return one 64-byte line as 8 beats of 64 bits; writes absorb 8 data beats.
- Serves as the simulation memory and the reference responder for core verification; handles one transaction at a time, no pipelining.

---
 rtl/sysbus_mem_responder.sv | 185 ++++++++++++++++++
 tb/tb_sysbus_mem_responder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sysbus_mem_responder.sv
// Sysbus memory-side responder.
// Accepts one line request at a time from a core-side initiator. Reads return
// a 64-byte line as 8 beats of 64 bits. Writes absorb 8 data beats into the
// backing array. All outputs come straight from flops.
module sysbus_mem_responder #(
  parameter int    MEM_WORDS     = 1048576,
  parameter int    LATENCY       = 4,
  parameter string MEM_INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reqcyc,
  input  logic [63:0] req,
  input  logic [12:0] reqtag,
  output logic        reqack,
  output logic        respcyc,
  output logic [63:0] resp,
  output logic [12:0] resptag,
  input  logic        respack
);

  // Word-address width of the backing array and the slice of the line
  // address that survives the modulo-MEM_WORDS wrap.
  localparam int AW     = $clog2(MEM_WORDS);
  localparam int LINE_W = (AW > 3) ? (AW - 3) : 1;
  localparam int LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [3:0]  TYPE_MEMORY = 4'h1;
  localparam logic [63:0] ALL_ONES    = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACK,
    S_WDATA,
    S_RWAIT,
    S_RDATA
  } state_t;

  state_t            state_q, state_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [12:0]       tag_q, tag_d;
  logic [2:0]        beat_q, beat_d;
  logic [LAT_W-1:0]  lat_q, lat_d;

  logic              reqack_q, reqack_d;
  logic              respcyc_q, respcyc_d;
  logic [63:0]       resp_q, resp_d;
  logic [12:0]       resptag_q, resptag_d;

  logic              mem_we;
  logic [AW-1:0]     wr_addr;
  logic [AW-1:0]     rd_addr;
  logic [LINE_W+2:0] wr_full;
  logic [LINE_W+2:0] rd_full;
  logic              next_is_mem;

  // Backing store; never reset, so committed writes survive a bus reset.
  // A hex image named by MEM_INIT_FILE is loaded by the simulation harness.
  logic [63:0] mem [MEM_WORDS];

  // Word addresses: line base concatenated with the beat, wrapped to the array.
  always_comb begin
    wr_full = {line_q, beat_q};
    rd_full = {line_d, beat_d};
    wr_addr = wr_full[AW-1:0];
    rd_addr = rd_full[AW-1:0];
  end

  // Next-state logic for the transaction FSM and its counters.
  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    tag_d   = tag_q;
    beat_d  = beat_q;
    lat_d   = lat_q;
    mem_we  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (reqcyc) begin
          line_d  = req[6+LINE_W-1:6];
          tag_d   = reqtag;
          beat_d  = 3'd0;
          state_d = S_ACK;
        end
      end

      S_ACK: begin
        beat_d = 3'd0;
        if (!tag_q[12]) begin
          state_d = S_WDATA;
        end else if (LATENCY == 1) begin
          state_d = S_RDATA;
        end else begin
          state_d = S_RWAIT;
          lat_d   = LAT_W'(LATENCY - 1);
        end
      end

      S_WDATA: begin
        if (reqcyc) begin
          mem_we = (tag_q[11:8] == TYPE_MEMORY);
          beat_d = beat_q + 3'd1;
          if (beat_q == 3'd7) begin
            state_d = S_IDLE;
          end
        end
      end

      S_RWAIT: begin
        lat_d = lat_q - LAT_W'(1);
        if (lat_q == LAT_W'(1)) begin
          state_d = S_RDATA;
        end
      end

      S_RDATA: begin
        if (respack) begin
          if (beat_q == 3'd7) begin
            beat_d  = 3'd0;
            state_d = S_IDLE;
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered outputs are computed from the upcoming state so that they line
  // up with state_q and no input reaches an output without a flop between.
  always_comb begin
    next_is_mem = (tag_d[11:8] == TYPE_MEMORY);
    reqack_d    = (state_d == S_ACK);
    respcyc_d   = (state_d == S_RDATA);
    resp_d      = 64'd0;
    resptag_d   = 13'd0;
    if (respcyc_d) begin
      resp_d    = next_is_mem ? mem[rd_addr] : ALL_ONES;
      resptag_d = tag_d;
    end
  end

  // State, counters and output flops with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      line_q    <= '0;
      tag_q     <= 13'd0;
      beat_q    <= 3'd0;
      lat_q     <= '0;
      reqack_q  <= 1'b0;
      respcyc_q <= 1'b0;
      resp_q    <= 64'd0;
      resptag_q <= 13'd0;
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      tag_q     <= tag_d;
      beat_q    <= beat_d;
      lat_q     <= lat_d;
      reqack_q  <= reqack_d;
      respcyc_q <= respcyc_d;
      resp_q    <= resp_d;
      resptag_q <= resptag_d;
    end
  end

  // Commit accepted write beats to the array.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_addr] <= req;
    end
  end

  assign reqack  = reqack_q;
  assign respcyc = respcyc_q;
  assign resp    = resp_q;
  assign resptag = resptag_q;

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Directed self-checking bench for sysbus_mem_responder (1024-word array).
module tb_sysbus_mem_responder;

  localparam int LAT = 4;

  logic        clk;
  logic        reset;
  logic        reqcyc;
  logic [63:0] req;
  logic [12:0] reqtag;
  logic        reqack;
  logic        respcyc;
  logic [63:0] resp;
  logic [12:0] resptag;
  logic        respack;

  int total;
  int bad;

  sysbus_mem_responder #(
    .MEM_WORDS(1024),
    .LATENCY(LAT),
    .MEM_INIT_FILE("")
  ) dut (
    .clk(clk),
    .reset(reset),
    .reqcyc(reqcyc),
    .req(req),
    .reqtag(reqtag),
    .reqack(reqack),
    .respcyc(respcyc),
    .resp(resp),
    .resptag(resptag),
    .respack(respack)
  );

  // 10 ns bus clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it and reports any difference.
  task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Write one line of beats base+0..base+7; optional 2-cycle stall after beat 3.
  task automatic applyWrite(input logic [63:0] addr, input logic [12:0] tag,
                            input logic [63:0] base, input bit stall, input string nm);
    @(negedge clk);
    reqcyc = 1'b1; req = addr; reqtag = tag;
    @(negedge clk);
    reqcyc = 1'b0; req = 64'd0;
    checkOutput({nm, "_reqack"}, {63'd0, reqack}, 64'd1);
    checkOutput({nm, "_respcyc_ack"}, {63'd0, respcyc}, 64'd0);
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      req = base + 64'(k); reqcyc = 1'b1;
      @(negedge clk);
      if (stall && k == 3) begin
        reqcyc = 1'b0; req = 64'hBAD0_BAD0_BAD0_BAD0;
        repeat (2) @(negedge clk);
      end
    end
    reqcyc = 1'b0; req = 64'd0;
    checkOutput({nm, "_idle_reqack"}, {63'd0, reqack}, 64'd0);
    checkOutput({nm, "_idle_respcyc"}, {63'd0, respcyc}, 64'd0);
  endtask

  // Read one line and check every cycle from ack through the last beat.
  task automatic applyRead(input logic [63:0] addr, input logic [12:0] tag,
                           input logic [63:0] base, input bit all_ones,
                           input int stall_beat, input int stall_cycles, input string nm);
    logic [63:0] exp_v;
    int holds;
    @(negedge clk);
    reqcyc = 1'b1; req = addr; reqtag = tag; respack = 1'b0;
    @(negedge clk);
    reqcyc = 1'b0; req = 64'd0;
    checkOutput({nm, "_reqack"}, {63'd0, reqack}, 64'd1);
    checkOutput({nm, "_respcyc_ack"}, {63'd0, respcyc}, 64'd0);
    for (int c = 0; c < LAT - 1; c++) begin
      @(negedge clk);
      checkOutput({nm, "_wait_reqack"}, {63'd0, reqack}, 64'd0);
      checkOutput({nm, "_wait_respcyc"}, {63'd0, respcyc}, 64'd0);
    end
    for (int k = 0; k < 8; k++) begin
      exp_v = all_ones ? 64'hFFFF_FFFF_FFFF_FFFF : base + 64'(k);
      holds = (k == stall_beat) ? stall_cycles : 0;
      for (int s = 0; s <= holds; s++) begin
        @(negedge clk);
        checkOutput({nm, "_respcyc"}, {63'd0, respcyc}, 64'd1);
        checkOutput({nm, "_resp"}, resp, exp_v);
        checkOutput({nm, "_resptag"}, {51'd0, resptag}, {51'd0, tag});
        checkOutput({nm, "_beat_reqack"}, {63'd0, reqack}, 64'd0);
        respack = (s == holds);
      end
    end
    @(negedge clk);
    respack = 1'b0;
    checkOutput({nm, "_end_respcyc"}, {63'd0, respcyc}, 64'd0);
    checkOutput({nm, "_end_resp"}, resp, 64'd0);
  endtask

  // Directed sequence.
  initial begin
    total = 0; bad = 0;
    reset = 1'b0; reqcyc = 1'b0; req = 64'd0; reqtag = 13'd0; respack = 1'b0;

    #1;
    checkOutput("rst_reqack", {63'd0, reqack}, 64'd0);
    checkOutput("rst_respcyc", {63'd0, respcyc}, 64'd0);
    checkOutput("rst_resp", resp, 64'd0);
    checkOutput("rst_resptag", {51'd0, resptag}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    $display("[TB] preload lines 0x0, 0x40, 0x1040 with word index values");
    applyWrite(64'h0000, 13'h0100, 64'h000, 1'b0, "wr_line0");
    applyWrite(64'h0040, 13'h0101, 64'h008, 1'b0, "wr_line1");
    applyWrite(64'h1040, 13'h0102, 64'h208, 1'b0, "wr_line41");

    $display("[TB] basic read at 0x1040");
    applyRead(64'h1040, 13'h1100, 64'h208, 1'b0, -1, 0, "rd_basic");

    $display("[TB] write 0x80 with stall, then read back");
    applyWrite(64'h0080, 13'h0100, 64'h0A0, 1'b1, "wr_stall");
    applyRead(64'h0080, 13'h1107, 64'h0A0, 1'b0, -1, 0, "rd_after_wr");

    $display("[TB] backpressure on beat 2");
    applyRead(64'h1040, 13'h1123, 64'h208, 1'b0, 2, 3, "rd_bp");

    $display("[TB] alignment and wrap");
    applyRead(64'h1047, 13'h1144, 64'h208, 1'b0, -1, 0, "rd_unaligned");
    applyRead(64'h2040, 13'h1155, 64'h008, 1'b0, 5, 1, "rd_wrap");

    $display("[TB] non-memory type");
    applyRead(64'h1040, 13'h12AB, 64'h0, 1'b1, -1, 0, "rd_nonmem");
    applyWrite(64'h0080, 13'h0203, 64'hDEAD_0000, 1'b0, "wr_nonmem");
    applyRead(64'h0080, 13'h1166, 64'h0A0, 1'b0, -1, 0, "rd_after_nonmem");

    $display("[TB] reset in the middle of a read beat");
    @(negedge clk);
    reqcyc = 1'b1; req = 64'h1040; reqtag = 13'h1100; respack = 1'b0;
    @(negedge clk);
    reqcyc = 1'b0; req = 64'd0;
    repeat (LAT) @(negedge clk);
    checkOutput("mid_beat0", resp, 64'h208);
    respack = 1'b1;
    @(negedge clk);
    respack = 1'b0;
    checkOutput("mid_beat1", resp, 64'h209);
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_reqack", {63'd0, reqack}, 64'd0);
    checkOutput("mid_rst_respcyc", {63'd0, respcyc}, 64'd0);
    checkOutput("mid_rst_resp", resp, 64'd0);
    checkOutput("mid_rst_resptag", {51'd0, resptag}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("post_rst_respcyc", {63'd0, respcyc}, 64'd0);
      checkOutput("post_rst_reqack", {63'd0, reqack}, 64'd0);
    end
    applyRead(64'h0000, 13'h1101, 64'h000, 1'b0, -1, 0, "rd_zero");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
